frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_pkg.sv | 19 +
 rtl/frame_sequencer_edge_detect.sv | 35 +++
 rtl/frame_sequencer.sv | 124 ++++++++++++
 tb/tb_frame_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// ---------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the frame sequencer block.
//   FRAME_CNT_W_DEFAULT : default width of the completed-swap counter
//   state_e             : sequencer FSM state encoding
// ---------------------------------------------------------------------------
package frame_pkg;

  localparam int FRAME_CNT_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CLEAR      = 3'd1,
    ST_DRAW       = 3'd2,
    ST_WAIT_VSYNC = 3'd3,
    ST_SWAP       = 3'd4
  } state_e;

endpackage

// File: rtl/frame_sequencer_edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Rising-edge detector for a level signal that is already synchronous to
// clk_i. The previous-cycle value is held in one register; the edge output
// is high in the cycle where the input is 1 and the stored value is 0.
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset (clears the stored value)
//   sig_i  : level input
//   rise_o : rising-edge indication
// ---------------------------------------------------------------------------
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;
  logic prev_d;

  assign prev_d = sig_i;

  // Previous-cycle copy of the input; cleared on reset so an input that is
  // already high when reset releases is treated as a fresh edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/frame_sequencer.sv
// ---------------------------------------------------------------------------
// frame_sequencer
// Double-buffered rendering loop controller: clears the back buffer, has the
// rasterizer draw into it, then waits for a vsync rising edge and swaps.
//   Clk               : system clock, rising edge
//   Reset_n           : synchronous active-low reset
//   enable            : run the rendering loop while high
//   vsync             : vertical sync level (synchronous to Clk)
//   clear_frame_start : level request to the frame-clear engine
//   clear_frame_done  : completion from the frame-clear engine
//   draw_start        : level request to the rasterizer
//   draw_done         : completion from the rasterizer
//   buffer_select     : displayed buffer index (back buffer is the other one)
//   frame_count       : completed-swap counter, wraps
//   frame_dropped     : one-cycle pulse when vsync arrives before the back
//                       buffer is finished
//   busy              : high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module frame_sequencer
  import frame_pkg::*;
#(
  parameter int FRAME_CNT_W = FRAME_CNT_W_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   enable,
  input  logic                   vsync,
  output logic                   clear_frame_start,
  input  logic                   clear_frame_done,
  output logic                   draw_start,
  input  logic                   draw_done,
  output logic                   buffer_select,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   frame_dropped,
  output logic                   busy
);

  state_e                 state_q;
  state_e                 state_d;
  logic                   buf_q;
  logic                   buf_d;
  logic [FRAME_CNT_W-1:0] count_q;
  logic [FRAME_CNT_W-1:0] count_d;
  logic                   dropped_q;
  logic                   dropped_d;
  logic                   vsync_rise;

  edge_detect u_vsync_edge (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .sig_i  (vsync),
    .rise_o (vsync_rise)
  );

  // State and datapath registers; reset wins over every input.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      buf_q     <= 1'b0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  // Next-state logic. Completion inputs are only looked at in the state
  // that issued the matching request, so stray pulses elsewhere are ignored.
  // enable is only sampled in IDLE and SWAP, so dropping it mid-loop lets
  // the current frame finish.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clear_frame_done) state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (draw_done) state_d = vsync_rise ? ST_SWAP : ST_WAIT_VSYNC;
      end
      ST_WAIT_VSYNC: begin
        if (vsync_rise) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        state_d = enable ? ST_CLEAR : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Swap bookkeeping and dropped-frame detection. A vsync edge that lands
  // while the back buffer is still being cleared or drawn is a missed frame;
  // it does not disturb the FSM, which keeps working toward the next vsync.
  always_comb begin
    buf_d     = buf_q;
    count_d   = count_q;
    dropped_d = 1'b0;
    if (state_q == ST_SWAP) begin
      buf_d   = ~buf_q;
      count_d = count_q + FRAME_CNT_W'(1);
    end
    if (vsync_rise &&
        ((state_q == ST_CLEAR) || ((state_q == ST_DRAW) && !draw_done))) begin
      dropped_d = 1'b1;
    end
  end

  // Moore outputs from the state register; the two requests decode from
  // distinct states so they can never overlap.
  assign clear_frame_start = (state_q == ST_CLEAR);
  assign draw_start        = (state_q == ST_DRAW);
  assign busy              = (state_q != ST_IDLE);
  assign buffer_select     = buf_q;
  assign frame_count       = count_q;
  assign frame_dropped     = dropped_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_sequencer
// Directed bench for frame_sequencer, built with a 2-bit frame counter so
// counter wrap is reachable in a handful of loops.
// ---------------------------------------------------------------------------
module tb_frame_sequencer;

  logic       Clk;
  logic       Reset_n;
  logic       enable;
  logic       vsync;
  logic       clear_frame_start;
  logic       clear_frame_done;
  logic       draw_start;
  logic       draw_done;
  logic       buffer_select;
  logic [1:0] frame_count;
  logic       frame_dropped;
  logic       busy;

  int errors;
  int checks;
  logic dropSeen;

  frame_sequencer #(.FRAME_CNT_W(2)) dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .enable            (enable),
    .vsync             (vsync),
    .clear_frame_start (clear_frame_start),
    .clear_frame_done  (clear_frame_done),
    .draw_start        (draw_start),
    .draw_done         (draw_done),
    .buffer_select     (buffer_select),
    .frame_count       (frame_count),
    .frame_dropped     (frame_dropped),
    .busy              (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Remembers whether frame_dropped was ever seen high since last cleared.
  always @(negedge Clk) begin
    if (frame_dropped === 1'b1) dropSeen = 1'b1;
  end

  // Advance one rising edge and settle just after it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic test_reset;
    enable = 1'b1; vsync = 1'b0; clear_frame_done = 1'b0; draw_done = 1'b0;
    Reset_n = 1'b0;
    step(3);
    checks++;
    if ({busy, clear_frame_start, draw_start, buffer_select, frame_count, frame_dropped} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b cs=%b ds=%b buf=%b cnt=%0d drop=%b, want all 0",
               busy, clear_frame_start, draw_start, buffer_select, frame_count, frame_dropped);
    end
    enable = 1'b0;
    Reset_n = 1'b1;
    step(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_hold: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_basic_loop;
    dropSeen = 1'b0;
    enable = 1'b1;
    step(1);
    checks++;
    if ({clear_frame_start, draw_start, busy} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL enter_clear: cs/ds/busy=%b, want 101", {clear_frame_start, draw_start, busy});
    end
    step(9);
    clear_frame_done = 1'b1;
    step(1);
    clear_frame_done = 1'b0;
    checks++;
    if ({clear_frame_start, draw_start} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL enter_draw: cs/ds=%b, want 01", {clear_frame_start, draw_start});
    end
    step(19);
    draw_done = 1'b1;
    step(1);
    draw_done = 1'b0;
    checks++;
    if ({clear_frame_start, draw_start, busy} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL enter_wait: cs/ds/busy=%b, want 001", {clear_frame_start, draw_start, busy});
    end
    step(4);
    vsync = 1'b1;
    step(1);
    checks++;
    if ({busy, clear_frame_start, draw_start, buffer_select, frame_count} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL swap_state: busy=%b cs=%b ds=%b buf=%b cnt=%0d, want 1 0 0 0 0",
               busy, clear_frame_start, draw_start, buffer_select, frame_count);
    end
    step(1);
    checks++;
    if ({buffer_select, frame_count, clear_frame_start} !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL after_swap: buf=%b cnt=%0d cs=%b, want buf=1 cnt=1 cs=1",
               buffer_select, frame_count, clear_frame_start);
    end
    checks++;
    if (dropSeen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_no_drop: dropped seen=%b, want 0", dropSeen);
    end
  endtask

  task automatic test_frame_drop;
    vsync = 1'b0;
    step(1);
    clear_frame_done = 1'b1;
    step(1);
    clear_frame_done = 1'b0;
    vsync = 1'b1;
    step(1);
    checks++;
    if ({frame_dropped, draw_start, buffer_select, frame_count} !== 5'b11101) begin
      errors++;
      $display("[TB] FAIL drop_pulse: drop=%b ds=%b buf=%b cnt=%0d, want 1 1 1 1",
               frame_dropped, draw_start, buffer_select, frame_count);
    end
    step(1);
    checks++;
    if ({frame_dropped, draw_start} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL drop_one_cycle: drop=%b ds=%b, want 0 1", frame_dropped, draw_start);
    end
    vsync = 1'b0;
    step(1);
  endtask

  task automatic test_back_to_back;
    dropSeen = 1'b0;
    draw_done = 1'b1;
    vsync = 1'b1;
    step(1);
    draw_done = 1'b0;
    checks++;
    if ({busy, clear_frame_start, draw_start} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL same_cycle_swap: busy/cs/ds=%b, want 100", {busy, clear_frame_start, draw_start});
    end
    step(1);
    checks++;
    if ({frame_count, buffer_select, dropSeen} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL same_cycle_count: cnt=%0d buf=%b drop=%b, want cnt=2 buf=0 drop=0",
               frame_count, buffer_select, dropSeen);
    end
  endtask

  task automatic test_enable_drop;
    vsync = 1'b0;
    step(1);
    clear_frame_done = 1'b1;
    step(1);
    clear_frame_done = 1'b0;
    enable = 1'b0;
    step(3);
    checks++;
    if ({draw_start, busy} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL no_abort: ds/busy=%b, want 11", {draw_start, busy});
    end
    draw_done = 1'b1;
    step(1);
    draw_done = 1'b0;
    step(1);
    vsync = 1'b1;
    step(2);
    checks++;
    if ({busy, frame_count, buffer_select} !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL finish_to_idle: busy=%b cnt=%0d buf=%b, want busy=0 cnt=3 buf=1",
               busy, frame_count, buffer_select);
    end
    clear_frame_done = 1'b1;
    draw_done = 1'b1;
    step(1);
    clear_frame_done = 1'b0;
    draw_done = 1'b0;
    step(2);
    checks++;
    if ({busy, clear_frame_start, draw_start, frame_count} !== 5'b00011) begin
      errors++;
      $display("[TB] FAIL idle_ignore: busy=%b cs=%b ds=%b cnt=%0d, want 0 0 0 3",
               busy, clear_frame_start, draw_start, frame_count);
    end
    vsync = 1'b0;
  endtask

  task automatic test_reset_midop;
    enable = 1'b1;
    step(1);
    clear_frame_done = 1'b1;
    step(1);
    clear_frame_done = 1'b0;
    Reset_n = 1'b0;
    draw_done = 1'b1;
    vsync = 1'b1;
    step(1);
    checks++;
    if ({busy, draw_start, frame_count, buffer_select, frame_dropped} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_midop: busy=%b ds=%b cnt=%0d buf=%b drop=%b, want all 0",
               busy, draw_start, frame_count, buffer_select, frame_dropped);
    end
    draw_done = 1'b0;
    vsync = 1'b0;
    Reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_wrap;
    logic [1:0] expCount [5];
    expCount = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int k = 0; k < 5; k++) begin
      step(1);
      clear_frame_done = 1'b1;
      step(1);
      clear_frame_done = 1'b0;
      draw_done = 1'b1;
      step(1);
      draw_done = 1'b0;
      vsync = 1'b1;
      step(1);
      vsync = 1'b0;
      step(1);
      checks++;
      if (frame_count !== expCount[k]) begin
        errors++;
        $display("[TB] FAIL wrap_count[%0d]: got %0d, want %0d", k, frame_count, expCount[k]);
      end
    end
    checks++;
    if (buffer_select !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_buffer: got %b, want 1", buffer_select);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    dropSeen = 1'b0;
    test_reset();
    test_basic_loop();
    test_frame_drop();
    test_back_to_back();
    test_enable_drop();
    test_reset_midop();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
